// File: rtl/alu_32_bit.sv
// alu_32_bit: registered 32-bit ALU for the execute stage.
//
// Sixteen operations (logic, shift, add/sub, compare, count leading ones or
// zeros) are selected by a 4-bit code. The result and the NZCV flags are
// captured on each rising clk edge, so the outputs follow the inputs with
// one cycle of latency. A new operation is accepted every cycle.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high; clears every output
//   result     out  32  registered operation result
//   carry      out  1   registered C flag (carry / borrow / last bit shifted out)
//   negative   out  1   registered N flag (result[31])
//   zero       out  1   registered Z flag (result == 0)
//   overflow   out  1   registered V flag (signed ADD/SUB overflow)
//   code       in   4   operation select
//   a          in   32  operand A
//   b          in   32  operand B, or the shift amount in b[4:0]
//   ovf_sticky out  1   only when ALU_STICKY_OVF_EN is defined: set by any
//                       edge that captures V=1, cleared only by reset
//
// Build option: define ALU_STICKY_OVF_EN to add the ovf_sticky output.

module alu_32_bit (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] result,
   output logic        carry,
   output logic        negative,
   output logic        zero,
   output logic        overflow,
   input  logic [3:0]  code,
   input  logic [31:0] a,
   input  logic [31:0] b
`ifdef ALU_STICKY_OVF_EN
   ,
   output logic        ovf_sticky
`endif
);

   localparam int DATA_W = 32;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SLLV = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRLV = 4'd7;
   localparam logic [3:0] OP_ADDU = 4'd8;
   localparam logic [3:0] OP_SUBU = 4'd9;
   localparam logic [3:0] OP_ADD  = 4'd10;
   localparam logic [3:0] OP_SUB  = 4'd11;
   localparam logic [3:0] OP_SLT  = 4'd12;
   localparam logic [3:0] OP_SLTU = 4'd13;
   localparam logic [3:0] OP_CLO  = 4'd14;
   localparam logic [3:0] OP_CLZ  = 4'd15;

   // Number of consecutive bits equal to 'lead' starting at the MSB (0..32).
   function automatic logic [5:0] lead_count(input logic [DATA_W-1:0] v,
                                              input logic              lead);
      logic [5:0] n;
      logic       stop;
      n    = 6'd0;
      stop = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (!stop) begin
            if (v[i] == lead) n = n + 6'd1;
            else              stop = 1'b1;
         end
      end
      return n;
   endfunction

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic [4:0]               sh_amt;
   logic [DATA_W:0]          sum_x;
   logic [DATA_W:0]          diff_x;
   logic [DATA_W:0]          shl_x;
   logic [DATA_W:0]          shr_x;

   logic [DATA_W-1:0]        res_p0;
   logic                     c_p0;
   logic                     v_p0;

   assign a_s    = a;
   assign b_s    = b;
   // SLL/SRL are fixed one-bit shifts; the variable forms use b[4:0] only.
   assign sh_amt = (code == OP_SLL || code == OP_SRL) ? 5'd1 : b[4:0];

   // The extra bit carries out of bit 31 (add), holds the borrow (sub), or
   // catches the last bit shifted out (shifts). A zero shift leaves it 0.
   assign sum_x  = {1'b0, a} + {1'b0, b};
   assign diff_x = {1'b0, a} - {1'b0, b};
   assign shl_x  = {1'b0, a} << sh_amt;
   assign shr_x  = {a, 1'b0} >> sh_amt;

   always_comb begin
      res_p0 = '0;
      c_p0   = 1'b0;
      v_p0   = 1'b0;
      case (code)
         OP_AND:  res_p0 = a & b;
         OP_OR:   res_p0 = a | b;
         OP_XOR:  res_p0 = a ^ b;
         OP_NOR:  res_p0 = ~(a | b);
         OP_SLL, OP_SLLV: begin
            res_p0 = shl_x[DATA_W-1:0];
            c_p0   = shl_x[DATA_W];
         end
         OP_SRL, OP_SRLV: begin
            res_p0 = shr_x[DATA_W:1];
            c_p0   = shr_x[0];
         end
         OP_ADDU: begin
            res_p0 = sum_x[DATA_W-1:0];
            c_p0   = sum_x[DATA_W];
         end
         OP_ADD: begin
            res_p0 = sum_x[DATA_W-1:0];
            c_p0   = sum_x[DATA_W];
            v_p0   = (a[31] == b[31]) && (sum_x[31] != a[31]);
         end
         OP_SUBU: begin
            res_p0 = diff_x[DATA_W-1:0];
            c_p0   = diff_x[DATA_W];
         end
         OP_SUB: begin
            res_p0 = diff_x[DATA_W-1:0];
            c_p0   = diff_x[DATA_W];
            v_p0   = (a[31] != b[31]) && (diff_x[31] != a[31]);
         end
         OP_SLT:  res_p0 = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: res_p0 = {{(DATA_W-1){1'b0}}, (a < b)};
         OP_CLO:  res_p0 = {{(DATA_W-6){1'b0}}, lead_count(a, 1'b1)};
         OP_CLZ:  res_p0 = {{(DATA_W-6){1'b0}}, lead_count(a, 1'b0)};
         default: res_p0 = '0;
      endcase
   end

   // ---- stage boundary: result and flags registered ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         carry    <= 1'b0;
         negative <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         result   <= res_p0;
         carry    <= c_p0;
         negative <= res_p0[DATA_W-1];
         zero     <= (res_p0 == '0);
         overflow <= v_p0;
      end
   end

`ifdef ALU_STICKY_OVF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     ovf_sticky <= 1'b0;
      else if (v_p0) ovf_sticky <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_alu_32_bit.sv
module tb_alu_32_bit;

   logic        clk;
   logic        reset;
   logic [31:0] result;
   logic        carry;
   logic        negative;
   logic        zero;
   logic        overflow;
   logic [3:0]  code;
   logic [31:0] a;
   logic [31:0] b;
`ifdef ALU_STICKY_OVF_EN
   logic        ovf_sticky;
`endif

   int checks = 0;
   int errors = 0;

   // Expected {result, N, Z, C, V}, pushed when an operation is driven.
   logic [35:0] sb[$];

   typedef struct {
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [35:0] e;
   } vec_t;

   logic [35:0] got;
   assign got = {result, negative, zero, carry, overflow};

   alu_32_bit dut (
      .clk      (clk),
      .reset    (reset),
      .result   (result),
      .carry    (carry),
      .negative (negative),
      .zero     (zero),
      .overflow (overflow),
      .code     (code),
      .a        (a),
      .b        (b)
`ifdef ALU_STICKY_OVF_EN
      ,
      .ovf_sticky (ovf_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference built from loops and 64-bit arithmetic.
   function automatic logic [35:0] model(input logic [3:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      logic [31:0] r;
      logic        c;
      logic        v;
      logic [63:0] us;
      longint      sa;
      longint      sb_;
      longint      ss;
      int          sh;
      int          k;
      int          cnt;
      r   = 32'h0;
      c   = 1'b0;
      v   = 1'b0;
      sa  = $signed(x);
      sb_ = $signed(y);
      ss  = 0;
      sh  = int'(y[4:0]);
      case (op)
         4'd0: r = x & y;
         4'd1: r = x | y;
         4'd2: r = x ^ y;
         4'd3: r = ~(x | y);
         4'd4: begin r = {x[30:0], 1'b0}; c = x[31]; end
         4'd5: begin
            r = x;
            for (int i = 0; i < sh; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end
         end
         4'd6: begin r = {1'b0, x[31:1]}; c = x[0]; end
         4'd7: begin
            r = x;
            for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[31:1]}; end
         end
         4'd8, 4'd10: begin
            us = {32'h0, x} + {32'h0, y};
            r  = us[31:0];
            c  = us[32];
            ss = sa + sb_;
            if (op == 4'd10) v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'd9, 4'd11: begin
            r  = x - y;
            c  = (x < y);
            ss = sa - sb_;
            if (op == 4'd11) v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'd12: r = (sa < sb_) ? 32'd1 : 32'd0;
         4'd13: r = (x < y) ? 32'd1 : 32'd0;
         default: begin
            k   = 31;
            cnt = 0;
            while (k >= 0 && x[k] == (op == 4'd14)) begin cnt++; k--; end
            r = 32'(cnt);
         end
      endcase
      return {r, r[31], (r == 32'h0), c, v};
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [35:0] e);
      @(negedge clk);
      code = op;
      a    = x;
      b    = y;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      code  = 4'd1;
      a     = 32'h1;
      b     = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got !== 36'h0) begin
         errors++;
         $display("FAIL reset_hold: got %h, want %h", got, 36'h0);
      end
`ifdef ALU_STICKY_OVF_EN
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset_sticky: got %b, want 0", ovf_sticky);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      // Operation that yields nonzero outputs, then reset between edges.
      drive(4'd3, 32'h0, 32'h0, {32'hFFFFFFFF, 4'b1000});
      @(posedge clk);
      #1;
      checks++;
      if (got !== sb.pop_front()) begin
         errors++;
         $display("FAIL pre_async_reset: got %h", got);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (got !== 36'h0) begin
         errors++;
         $display("FAIL async_reset: got %h, want %h", got, 36'h0);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_logic_arith();
      vec_t tv[$];
      logic [35:0] e;
      tv.push_back('{4'd0,  32'hAAAAAAAA, 32'h55555555, {32'h00000000, 4'b0100}});
      tv.push_back('{4'd1,  32'h12345678, 32'h9ABCDEF0, {32'h9ABCDEF8, 4'b1000}});
      tv.push_back('{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, {32'h0FF00FF0, 4'b0000}});
      tv.push_back('{4'd3,  32'h00000000, 32'h00000000, {32'hFFFFFFFF, 4'b1000}});
      tv.push_back('{4'd8,  32'hFFFFFFFF, 32'h00000001, {32'h00000000, 4'b0110}});
      tv.push_back('{4'd10, 32'h7FFFFFFF, 32'h00000001, {32'h80000000, 4'b1001}});
      tv.push_back('{4'd8,  32'h80000000, 32'h80000000, {32'h00000000, 4'b0110}});
      tv.push_back('{4'd10, 32'h80000000, 32'h80000000, {32'h00000000, 4'b0111}});
      tv.push_back('{4'd11, 32'h80000000, 32'h00000001, {32'h7FFFFFFF, 4'b0001}});
      tv.push_back('{4'd9,  32'h00000001, 32'h00000002, {32'hFFFFFFFF, 4'b1010}});
      tv.push_back('{4'd11, 32'h00000005, 32'h00000005, {32'h00000000, 4'b0100}});
      tv.push_back('{4'd12, 32'hFFFFFFFF, 32'h00000001, {32'h00000001, 4'b0000}});
      tv.push_back('{4'd13, 32'hFFFFFFFF, 32'h00000001, {32'h00000000, 4'b0100}});
      foreach (tv[i]) begin
         drive(tv[i].op, tv[i].x, tv[i].y, tv[i].e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL logic_arith[%0d] op=%0d: got %h, want %h", i, tv[i].op, got, e);
         end
      end
   endtask

   task automatic test_shift_count();
      vec_t tv[$];
      logic [35:0] e;
      tv.push_back('{4'd5,  32'h10000001, 32'h00000004, {32'h00000010, 4'b0010}});
      tv.push_back('{4'd7,  32'h80000003, 32'h00000021, {32'h40000001, 4'b0010}});
      tv.push_back('{4'd4,  32'h80000000, 32'h00000000, {32'h00000000, 4'b0110}});
      tv.push_back('{4'd6,  32'h00000001, 32'h00000000, {32'h00000000, 4'b0110}});
      tv.push_back('{4'd5,  32'h12345678, 32'hFFFFFFE0, {32'h12345678, 4'b0000}});
      tv.push_back('{4'd7,  32'h80000000, 32'h0000001F, {32'h00000001, 4'b0000}});
      tv.push_back('{4'd15, 32'h00010000, 32'h00000000, {32'h0000000F, 4'b0000}});
      tv.push_back('{4'd15, 32'h00000000, 32'h00000000, {32'h00000020, 4'b0000}});
      tv.push_back('{4'd14, 32'hF0000000, 32'h00000000, {32'h00000004, 4'b0000}});
      tv.push_back('{4'd14, 32'h7FFFFFFF, 32'h00000000, {32'h00000000, 4'b0100}});
      tv.push_back('{4'd14, 32'hFFFFFFFF, 32'h00000000, {32'h00000020, 4'b0000}});
      foreach (tv[i]) begin
         drive(tv[i].op, tv[i].x, tv[i].y, tv[i].e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL shift_count[%0d] op=%0d: got %h, want %h", i, tv[i].op, got, e);
         end
      end
   endtask

   task automatic test_latency();
      logic [35:0] e;
      drive(4'd2, 32'h0000FFFF, 32'h00FF00FF, {32'h00FFFF00, 4'b0000});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL latency_first: got %h, want %h", got, e);
      end
      // Inputs change mid-cycle; outputs must hold until the next edge.
      #2;
      code = 4'd3;
      a    = 32'h0;
      b    = 32'h0;
      sb.push_back({32'hFFFFFFFF, 4'b1000});
      #1;
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL latency_hold: got %h, want %h", got, e);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL latency_update: got %h, want %h", got, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] corners[6];
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [35:0] e;
      int          bad = 0;
      corners[0] = 32'h00000000; corners[1] = 32'hFFFFFFFF;
      corners[2] = 32'h80000000; corners[3] = 32'h7FFFFFFF;
      corners[4] = 32'h00000001; corners[5] = 32'h0000001F;
      for (int n = 0; n < 400; n++) begin
         op = 4'($urandom_range(0, 15));
         x  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         y  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         drive(op, x, y, model(op, x, y));
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL back_to_back[%0d] op=%0d a=%h b=%h: got %h, want %h",
                        n, op, x, y, got, e);
         end
      end
   endtask

`ifdef ALU_STICKY_OVF_EN
   task automatic test_sticky();
      drive(4'd10, 32'h00000001, 32'h00000001, {32'h00000002, 4'b0000});
      @(posedge clk);
      #1;
      void'(sb.pop_front());
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear: got %b, want 0", ovf_sticky);
      end
      drive(4'd10, 32'h7FFFFFFF, 32'h00000001, {32'h80000000, 4'b1001});
      @(posedge clk);
      #1;
      void'(sb.pop_front());
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL sticky_set: got %b, want 1", ovf_sticky);
      end
      drive(4'd0, 32'h0, 32'h0, {32'h0, 4'b0100});
      drive(4'd10, 32'h1, 32'h2, {32'h3, 4'b0000});
      @(posedge clk);
      #1;
      sb.delete();
      checks++;
      if (ovf_sticky !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL sticky_hold: got %b/%b, want 1/0", ovf_sticky, overflow);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL sticky_reset: got %b, want 0", ovf_sticky);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_logic_arith();
      test_shift_count();
      test_latency();
      test_back_to_back();
`ifdef ALU_STICKY_OVF_EN
      test_sticky();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
